// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the 64-word data memory between the single-cycle core (CPU port)
// and an external loader/debug master (EXT port). The CPU has priority. EXT
// is never starved: after MAX_WAIT consecutive lost cycles, EXT receives one
// forced grant even if the CPU is requesting.
//
// Parameters
//   DATA_W    data word width
//   ADDR_W    word-address width
//   DEPTH     number of memory words; addresses >= DEPTH are out of range
//   MAX_WAIT  denied EXT cycles before a forced EXT grant (1..15)
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   cpu_req/we/addr/wdata   CPU access request (load or store)
//   cpu_gnt, cpu_rdata      comb. grant and load data (0 when not granted or
//                           out of range)
//   ext_req/we/addr/wdata   EXT access request, held until ext_gnt
//   ext_gnt                 comb. EXT grant
//   ext_rvalid, ext_rdata   registered read response, one cycle after grant
//   ext_err                 registered pulse after an out-of-range EXT access
//   mem_addr/wdata/we       to memory (memory writes on negedge of grant cycle)
//   mem_rdata               from memory, combinational read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [3:0]        MAX_W    = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_CPU,
    S_WAIT,
    S_FORCE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
  logic [3:0] wait_cnt_inc;

  logic       cpu_in_range;
  logic       ext_in_range;
  logic       ext_rd_ok;

  assign cpu_in_range = (cpu_addr < DEPTH_A);
  assign ext_in_range = (ext_addr < DEPTH_A);
  assign wait_cnt_inc = wait_cnt + 4'd1;

  // ---------------------------------------------------------------------------
  // Next-state and grant logic. Grants are held at 0 during reset so that no
  // memory access can occur while the arbiter is being initialised.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    cpu_gnt      = 1'b0;
    ext_gnt      = 1'b0;

    if (rst_n) begin
      unique case (state)
        S_CPU: begin
          wait_cnt_nxt = '0;
          if (cpu_req) begin
            cpu_gnt = 1'b1;
            if (ext_req) begin
              // First lost cycle already counts; with MAX_WAIT=1 it is enough.
              wait_cnt_nxt = 4'd1;
              state_nxt    = (MAX_W <= 4'd1) ? S_FORCE : S_WAIT;
            end
          end else if (ext_req) begin
            ext_gnt = 1'b1;
          end
        end

        S_WAIT: begin
          if (!ext_req) begin
            cpu_gnt      = cpu_req;
            wait_cnt_nxt = '0;
            state_nxt    = S_CPU;
          end else if (!cpu_req) begin
            ext_gnt      = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = S_CPU;
          end else begin
            cpu_gnt      = 1'b1;
            wait_cnt_nxt = wait_cnt_inc;
            if (wait_cnt_inc >= MAX_W) begin
              state_nxt = S_FORCE;
            end
          end
        end

        S_FORCE: begin
          // One cycle owned by EXT; an absent request simply wastes the slot.
          ext_gnt      = ext_req;
          wait_cnt_nxt = '0;
          state_nxt    = S_CPU;
        end

        default: begin
          wait_cnt_nxt = '0;
          state_nxt    = S_CPU;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side mux. With no grant the CPU port is presented so the address
  // bus is stable for the core's next access.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr  = ext_gnt ? ext_addr  : cpu_addr;
    mem_wdata = ext_gnt ? ext_wdata : cpu_wdata;
    mem_we    = (cpu_gnt & cpu_we & cpu_in_range) |
                (ext_gnt & ext_we & ext_in_range);
  end

  assign cpu_rdata = (cpu_gnt && cpu_in_range) ? mem_rdata : '0;

  assign ext_rd_ok = ext_gnt & ~ext_we & ext_in_range;

  // ---------------------------------------------------------------------------
  // State register and registered EXT response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
      ext_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      ext_rvalid <= ext_rd_ok;
      ext_err    <= ext_gnt & ~ext_in_range;
      if (ext_rd_ok) begin
        ext_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a 64-word behavioural memory that
// writes on negedge and reads combinationally. Inputs change 1 time unit after
// posedge; outputs are sampled 4 units after posedge (before the negedge).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic        ext_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic        oob_write;

  int n_checks;
  int n_fail;

  dmem_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .DEPTH    (64),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .ext_err    (ext_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory; out-of-range reads return a poison pattern so that
  // the arbiter's zeroing of cpu_rdata is observable.
  assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'hA5A5_A5A5;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      oob_write <= 1'b0;
    end else if (mem_we) begin
      if (mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
      else                   oob_write <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  // Five cycles of continuous conflict starting from S_CPU with wait_cnt=0:
  // four CPU grants followed by one forced EXT grant.
  task automatic conflict_run(input string tag, input bit skip_first_tick);
    for (int k = 0; k < 5; k++) begin
      if (!(skip_first_tick && k == 0)) tick();
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd10, 32'd0);
      settle();
      check($sformatf("%s_cpu_gnt%0d", tag, k), {31'd0, cpu_gnt}, (k == 4) ? 32'd0 : 32'd1);
      check($sformatf("%s_ext_gnt%0d", tag, k), {31'd0, ext_gnt}, (k == 4) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // 1: reset with both requests high
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'd3, 32'h1111_1111, 1'b1, 1'b1, 32'd4, 32'h2222_2222);
    tick(); settle();
    check("rst_cpu_gnt_a", {31'd0, cpu_gnt}, 32'd0);
    check("rst_ext_gnt_a", {31'd0, ext_gnt}, 32'd0);
    check("rst_mem_we_a",  {31'd0, mem_we},  32'd0);
    tick(); settle();
    check("rst_cpu_gnt_b", {31'd0, cpu_gnt},    32'd0);
    check("rst_ext_gnt_b", {31'd0, ext_gnt},    32'd0);
    check("rst_mem_we_b",  {31'd0, mem_we},     32'd0);
    check("rst_rvalid",    {31'd0, ext_rvalid}, 32'd0);
    check("rst_err",       {31'd0, ext_err},    32'd0);
    check("rst_rdata",     ext_rdata,           32'd0);

    // 2: CPU store then load
    tick(); rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    check("cpu_st_gnt",  {31'd0, cpu_gnt}, 32'd1);
    check("cpu_st_egnt", {31'd0, ext_gnt}, 32'd0);
    check("cpu_st_we",   {31'd0, mem_we},  32'd1);
    check("cpu_st_addr", mem_addr,         32'd5);
    tick();
    drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    check("cpu_ld_gnt",   {31'd0, cpu_gnt}, 32'd1);
    check("cpu_ld_we",    {31'd0, mem_we},  32'd0);
    check("cpu_ld_rdata", cpu_rdata,        32'hDEAD_BEEF);

    // 3: EXT write then read
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd10, 32'h0000_1234);
    settle();
    check("ext_wr_gnt",  {31'd0, ext_gnt}, 32'd1);
    check("ext_wr_cgnt", {31'd0, cpu_gnt}, 32'd0);
    check("ext_wr_we",   {31'd0, mem_we},  32'd1);
    check("ext_wr_addr", mem_addr,         32'd10);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd10, 32'd0);
    settle();
    check("ext_rd_gnt",      {31'd0, ext_gnt},    32'd1);
    check("ext_wr_no_rvld",  {31'd0, ext_rvalid}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    check("ext_rd_rvalid", {31'd0, ext_rvalid}, 32'd1);
    check("ext_rd_rdata",  ext_rdata,           32'h0000_1234);
    tick(); settle();
    check("ext_rvalid_pulse", {31'd0, ext_rvalid}, 32'd0);
    check("ext_rdata_hold",   ext_rdata,           32'h0000_1234);

    // 4: starvation, two full periods
    for (int k = 0; k < 10; k++) begin
      tick();
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd10, 32'd0);
      settle();
      check($sformatf("starve_cpu_gnt%0d", k), {31'd0, cpu_gnt}, (k % 5 == 4) ? 32'd0 : 32'd1);
      check($sformatf("starve_ext_gnt%0d", k), {31'd0, ext_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
      if (k % 5 == 4) begin
        check($sformatf("starve_addr%0d", k),  mem_addr,  32'd10);
        check($sformatf("starve_crd%0d", k),   cpu_rdata, 32'd0);
      end
      if (k == 5) begin
        check("starve_rvalid", {31'd0, ext_rvalid}, 32'd1);
        check("starve_rdata",  ext_rdata,           32'h0000_1234);
      end
    end
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    check("starve_rvalid2", {31'd0, ext_rvalid}, 32'd1);

    // EXT drops its request in S_WAIT: counter must restart from zero
    tick(); drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd10, 32'd0);
    tick(); drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd10, 32'd0);
    tick(); drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd10, 32'd0);
    settle();
    check("drop_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("drop_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    conflict_run("drop", 1'b0);

    // 5: out-of-range accesses
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd64, 32'h0000_FFFF);
    settle();
    check("oor_ext_gnt", {31'd0, ext_gnt}, 32'd1);
    check("oor_ext_we",  {31'd0, mem_we},  32'd0);
    tick();
    drive(1'b1, 1'b0, 32'd70, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    check("oor_ext_err",   {31'd0, ext_err},    32'd1);
    check("oor_no_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("oor_cpu_gnt",   {31'd0, cpu_gnt},    32'd1);
    check("oor_cpu_rdata", cpu_rdata,           32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd100, 32'd0);
    settle();
    check("oor_err_pulse", {31'd0, ext_err},   32'd0);
    check("oor_mem_clean", {31'd0, oob_write}, 32'd0);
    check("oor_rd_gnt",    {31'd0, ext_gnt},   32'd1);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    check("oor_rd_err",    {31'd0, ext_err},    32'd1);
    check("oor_rd_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("oor_rd_hold",   ext_rdata,           32'h0000_1234);

    // 6: reset on the edge ending a granted EXT read
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
    settle();
    check("rstrd_gnt", {31'd0, ext_gnt}, 32'd1);
    #4 rst_n = 1'b0;
    tick(); settle();
    check("rstrd_no_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("rstrd_rdata",     ext_rdata,           32'd0);
    check("rstrd_gnt_off",   {31'd0, ext_gnt},    32'd0);
    tick(); rst_n = 1'b1;
    conflict_run("rstrd", 1'b1);

    // Reset while in S_WAIT must clear the starvation count
    tick(); drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd10, 32'd0);
    tick();
    tick(); settle();
    #4 rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    conflict_run("rstwait", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
